// File: rtl/mii_rx_frame_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes
// (low nibble first), checks the CRC-32 residue and reports per-frame status.
module mii_rx_frame_deframer #(
    parameter int unsigned MIN_PRE = 8,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        clk_25Mz,
    input  logic        reset,
    input  logic        RX_DV,
    input  logic        RX_ER,
    input  logic [3:0]  DATA,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        frame_done,
    output logic [10:0] frame_len,
    output logic        crc_ok,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [31:0] CRC_INIT = '1;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA_LO, S_DATA_HI, S_END, S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic        dv_q, er_q;
    logic [3:0]  nib_q;
    logic [3:0]  pre_cnt_q, lo_q;
    logic        sof_pend_q, er_flag_q, align_q;
    logic [10:0] len_q;
    logic [31:0] crc_q;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q, rx_sof_q, frame_done_q, crc_ok_q, frame_err_q;
    logic [10:0] frame_len_q;
    logic [15:0] frame_cnt_q, err_cnt_q;

    logic sfd_ok;
    logic pre_start, pre_step, sfd_hit, pre_abort;
    logic lo_latch, byte_fire, dribble, er_hit, frame_end, frame_bad;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign sfd_ok = (nib_q == 4'hD) && (32'(pre_cnt_q) >= MIN_PRE);

    // Register the PHY pins once; everything downstream uses these copies
    always_ff @(posedge clk_25Mz) begin
        if (reset) begin
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
            nib_q <= '0;
        end else begin
            dv_q  <= RX_DV;
            er_q  <= RX_ER;
            nib_q <= DATA;
        end
    end

    // State register
    always_ff @(posedge clk_25Mz) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; END also watches for a new preamble so a frame
    // following after a single idle cycle keeps its first nibble
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_END: begin
                state_d = S_IDLE;
                if (dv_q) state_d = (nib_q == 4'h5) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
                if (!dv_q)                state_d = S_IDLE;
                else if (nib_q == 4'h5)   state_d = S_PREAMBLE;
                else if (sfd_ok)          state_d = S_DATA_LO;
                else                      state_d = S_DROP;
            end
            S_DATA_LO: state_d = dv_q ? S_DATA_HI : S_END;
            S_DATA_HI: state_d = dv_q ? S_DATA_LO : S_END;
            S_DROP:    state_d = dv_q ? S_DROP : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Decode per-cycle datapath events from state and sampled inputs
    always_comb begin
        pre_start = 1'b0;
        pre_step  = 1'b0;
        sfd_hit   = 1'b0;
        pre_abort = 1'b0;
        lo_latch  = 1'b0;
        byte_fire = 1'b0;
        dribble   = 1'b0;
        case (state_q)
            S_IDLE, S_END: pre_start = dv_q && (nib_q == 4'h5);
            S_PREAMBLE: begin
                if (!dv_q)              pre_abort = 1'b1;
                else if (nib_q == 4'h5) pre_step  = 1'b1;
                else if (sfd_ok)        sfd_hit   = 1'b1;
                else                    pre_abort = 1'b1;
            end
            S_DATA_LO: lo_latch = dv_q;
            S_DATA_HI: begin
                byte_fire = dv_q;
                dribble   = !dv_q;
            end
            default: ;
        endcase
        frame_end = (state_q == S_END);
        er_hit    = dv_q && er_q && ((state_q == S_DATA_LO) || (state_q == S_DATA_HI));
        frame_bad = er_flag_q || align_q || (crc_q != RESIDUE) ||
                    (32'(len_q) < MIN_LEN) || (32'(len_q) > MAX_LEN);
    end

    // Datapath: byte assembly, length/CRC accumulation, status and counters
    always_ff @(posedge clk_25Mz) begin
        if (reset) begin
            pre_cnt_q    <= '0;
            lo_q         <= '0;
            sof_pend_q   <= 1'b0;
            er_flag_q    <= 1'b0;
            align_q      <= 1'b0;
            len_q        <= '0;
            crc_q        <= CRC_INIT;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            crc_ok_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            rx_valid_q   <= byte_fire;
            rx_sof_q     <= byte_fire && sof_pend_q;
            frame_done_q <= frame_end;

            if (pre_start)                      pre_cnt_q <= 4'd1;
            else if (pre_step && pre_cnt_q != '1) pre_cnt_q <= pre_cnt_q + 4'd1;

            if (sfd_hit) begin
                sof_pend_q <= 1'b1;
                len_q      <= '0;
                crc_q      <= CRC_INIT;
                er_flag_q  <= 1'b0;
                align_q    <= 1'b0;
            end

            if (lo_latch) lo_q <= nib_q;
            if (er_hit)   er_flag_q <= 1'b1;
            if (dribble)  align_q <= 1'b1;

            if (byte_fire) begin
                rx_byte_q  <= {nib_q, lo_q};
                sof_pend_q <= 1'b0;
                if (len_q != '1) len_q <= len_q + 11'd1;
                crc_q      <= crc32_byte(crc_q, {nib_q, lo_q});
            end

            if (frame_end) begin
                frame_len_q <= len_q;
                crc_ok_q    <= (crc_q == RESIDUE);
                frame_err_q <= frame_bad;
                er_flag_q   <= 1'b0;
                align_q     <= 1'b0;
                sof_pend_q  <= 1'b0;
                if (!frame_bad) begin
                    if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 16'd1;
                end else begin
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
                end
            end

            if (pre_abort && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign rx_sof     = rx_sof_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign crc_ok     = crc_ok_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mii_rx_frame_deframer.sv
// Bench for mii_rx_frame_deframer: frames are described as byte lists,
// the expected byte stream and status are derived from the frame description.
`timescale 1ns/1ps
module tb_mii_rx_frame_deframer;

    localparam int MIN_PRE = 8;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk_25Mz = 1'b0;
    logic        reset;
    logic        RX_DV, RX_ER;
    logic [3:0]  DATA;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_sof, frame_done, crc_ok, frame_err;
    logic [10:0] frame_len;
    logic [15:0] frame_cnt, err_cnt;

    mii_rx_frame_deframer #(
        .MIN_PRE(MIN_PRE),
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk_25Mz  (clk_25Mz),
        .reset     (reset),
        .RX_DV     (RX_DV),
        .RX_ER     (RX_ER),
        .DATA      (DATA),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .frame_done(frame_done),
        .frame_len (frame_len),
        .crc_ok    (crc_ok),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #20 clk_25Mz = ~clk_25Mz;

    typedef struct packed {
        logic [10:0] len;
        logic        ok;
        logic        err;
    } done_t;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_b[$];
    logic [8:0] got_b[$];
    done_t      exp_d[$];
    done_t      got_d[$];
    logic [7:0] fb[$];
    bit         fb_bad;
    int         exp_frm = 0;
    int         exp_err = 0;
    int         spacing_viol = 0;
    logic       prev_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Collect everything the DUT emits
    always @(negedge clk_25Mz) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (rx_valid) got_b.push_back({rx_sof, rx_byte});
            if (frame_done) got_d.push_back({frame_len, crc_ok, frame_err});
            if (rx_valid && prev_valid) spacing_viol <= spacing_viol + 1;
            prev_valid <= rx_valid;
        end
    end

    initial begin
        #3600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic dv, input logic er, input logic [3:0] n);
        RX_DV = dv;
        RX_ER = er;
        DATA  = n;
        @(negedge clk_25Mz);
    endtask

    // n bytes total: random payload followed by its FCS (LSB first)
    task automatic build(input int n, input bit bad);
        logic [31:0] c;
        logic [7:0]  b;
        fb.delete();
        for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
        c = 32'hFFFFFFFF;
        foreach (fb[i]) begin
            b = fb[i];
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            b = c[8*k +: 8];
            fb.push_back(b);
        end
        if (bad) fb[n-1] = fb[n-1] ^ 8'h01;
        fb_bad = bad;
    endtask

    // Drive the current frame and record what the receiver should report
    task automatic send(input int pre_n, input bit drib, input int er_idx, input int gap);
        int    len;
        bit    er_any, err;
        done_t d;
        logic [7:0] b;
        for (int i = 0; i < pre_n; i++) put(1'b1, 1'b0, 4'h5);
        put(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < fb.size(); i++) begin
            b = fb[i];
            put(1'b1, er_idx == 2*i,     b[3:0]);
            put(1'b1, er_idx == 2*i + 1, b[7:4]);
        end
        if (drib) put(1'b1, 1'b0, 4'($urandom));
        for (int i = 0; i < gap; i++) put(1'b0, 1'b0, 4'h0);

        if (pre_n < MIN_PRE) begin
            exp_err++;
        end else begin
            len    = (fb.size() > 2047) ? 2047 : fb.size();
            er_any = (er_idx >= 0) && (er_idx < 2 * fb.size());
            foreach (fb[i]) exp_b.push_back({i == 0, fb[i]});
            err   = er_any || drib || fb_bad || (len < MIN_LEN) || (len > MAX_LEN);
            d.len = 11'(len);
            d.ok  = !fb_bad;
            d.err = err;
            exp_d.push_back(d);
            if (err) exp_err++;
            else     exp_frm++;
        end
    endtask

    task automatic drain(input string tag);
        repeat (8) put(1'b0, 1'b0, 4'h0);
        check_val({tag, "/nbytes"}, 32'(got_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            check_val({tag, "/byte"}, 32'(got_b[i]), 32'(exp_b[i]));
        check_val({tag, "/ndone"}, 32'(got_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check_val({tag, "/len"},   32'(got_d[i].len), 32'(exp_d[i].len));
            check_val({tag, "/crcok"}, 32'(got_d[i].ok),  32'(exp_d[i].ok));
            check_val({tag, "/err"},   32'(got_d[i].err), 32'(exp_d[i].err));
        end
        check_val({tag, "/frame_cnt"}, 32'(frame_cnt), 32'(exp_frm));
        check_val({tag, "/err_cnt"},   32'(err_cnt),   32'(exp_err));
        check_val({tag, "/spacing"},   32'(spacing_viol), 32'd0);
        exp_b.delete();
        got_b.delete();
        exp_d.delete();
        got_d.delete();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "/rx_byte"},    32'(rx_byte),    32'd0);
        check_val({tag, "/rx_valid"},   32'(rx_valid),   32'd0);
        check_val({tag, "/rx_sof"},     32'(rx_sof),     32'd0);
        check_val({tag, "/frame_done"}, 32'(frame_done), 32'd0);
        check_val({tag, "/frame_len"},  32'(frame_len),  32'd0);
        check_val({tag, "/crc_ok"},     32'(crc_ok),     32'd0);
        check_val({tag, "/frame_err"},  32'(frame_err),  32'd0);
        check_val({tag, "/frame_cnt"},  32'(frame_cnt),  32'd0);
        check_val({tag, "/err_cnt"},    32'(err_cnt),    32'd0);
    endtask

    initial begin
        int n, pre, er, gap;
        bit bad, drib;
        logic [7:0] b;

        reset = 1'b1;
        RX_DV = 1'b0;
        RX_ER = 1'b0;
        DATA  = 4'h0;
        repeat (3) @(negedge clk_25Mz);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk_25Mz);

        build(64, 0); send(15, 0, -1, 2); drain("good64");
        fb[63] = fb[63] ^ 8'h01; fb_bad = 1;
        send(15, 0, -1, 2); drain("badfcs");
        build(64, 0); send(4, 0, -1, 2); drain("pre4");
        build(64, 0); send(7, 0, -1, 2); drain("pre7");
        build(64, 0); send(15, 1, -1, 2); drain("dribble");

        build(64, 0); send(8, 0, -1, 1);
        build(64, 0); send(8, 0, -1, 1);
        build(60, 0); send(8, 0, -1, 3);
        drain("b2b");

        // RX_ER mid-frame, reset 10 cycles later while still in the frame
        build(64, 0);
        for (int i = 0; i < 15; i++) put(1'b1, 1'b0, 4'h5);
        put(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 15; i++) begin
            b = fb[i];
            put(1'b1, 2*i == 20,     b[3:0]);
            put(1'b1, 2*i + 1 == 20, b[7:4]);
        end
        reset = 1'b1;
        RX_DV = 1'b0;
        RX_ER = 1'b0;
        repeat (2) @(negedge clk_25Mz);
        reset = 1'b0;
        @(negedge clk_25Mz);
        check_zero("midreset");
        got_b.delete(); got_d.delete(); exp_b.delete(); exp_d.delete();
        exp_frm = 0;
        exp_err = 0;
        drain("after_reset");
        build(64, 0); send(12, 0, -1, 2); drain("post_reset");

        build(64, 0);   send(9, 0, 127, 2); drain("er_last");
        build(63, 0);   send(10, 0, -1, 2); drain("len63");
        build(1518, 0); send(8, 0, -1, 2);  drain("len1518");
        build(1519, 0); send(8, 0, -1, 2);  drain("len1519");

        for (int it = 0; it < 25; it++) begin
            n    = ($urandom_range(0, 2) == 0) ? 64 : int'($urandom_range(5, 140));
            pre  = int'($urandom_range(1, 15));
            bad  = ($urandom_range(0, 3) == 0);
            drib = ($urandom_range(0, 4) == 0);
            er   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2*n - 1)) : -1;
            gap  = int'($urandom_range(1, 4));
            build(n, bad);
            send(pre, drib, er, gap);
            if (it % 3 == 2) drain("random");
        end
        drain("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
